// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: default word
// width, FSM state encoding, grant encoding and the round-robin pick rule.
package mem_arbiter_pkg;

    localparam int WORD_SIZE = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

    // A lone requester always wins; on a conflict the side that did not win
    // the previous grant is chosen.
    function automatic grant_e pick_grant(input logic ireq, input logic dreq,
                                          input grant_e last);
        grant_e g;
        if (ireq && dreq) begin
            if (last == GRANT_I) begin
                g = GRANT_D;
            end else begin
                g = GRANT_I;
            end
        end else if (dreq) begin
            g = GRANT_D;
        end else begin
            g = GRANT_I;
        end
        return g;
    endfunction

endpackage

// File: rtl/access_counter.sv
// Wrapping completion counter: adds one on every enabled cycle, rolls over
// from all-ones to zero, cleared by the asynchronous reset.
module access_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: increment when enabled, natural modulo-2^WIDTH wrap.
    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single memory
// port. One access at a time: IDLE grants, BUSY drives the strobe until the
// memory answers, DONE pulses the acknowledge. Conflicts are round-robin.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WORD_SIZE = mem_arbiter_pkg::WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic                 i_ack,
    output logic [WORD_SIZE-1:0] i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_ack,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ready,
    output logic [WORD_SIZE-1:0] num_iacc,
    output logic [WORD_SIZE-1:0] num_dacc
);

    state_e               state_q, state_d;
    grant_e               last_grant_q, last_grant_d;
    grant_e               cur_grant_q, cur_grant_d;
    grant_e               grant_s;
    logic                 mem_read_q, mem_read_d;
    logic                 mem_write_q, mem_write_d;
    logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
    logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
    logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
    logic                 i_ack_q, i_ack_d;
    logic                 d_ack_q, d_ack_d;
    logic                 i_done_s;
    logic                 d_done_s;

    assign grant_s = pick_grant(i_req, d_req, last_grant_q);

    // Next-state and next-output logic. Acks are armed on the completing
    // BUSY edge so they are high for exactly the DONE cycle; mem_ready is
    // only looked at in BUSY.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cur_grant_d  = cur_grant_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        i_done_s     = 1'b0;
        d_done_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    cur_grant_d  = grant_s;
                    last_grant_d = grant_s;
                    state_d      = BUSY;
                    if (grant_s == GRANT_D) begin
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_read_d  = ~d_we;
                        mem_write_d = d_we;
                    end else begin
                        mem_addr_d  = i_addr;
                        mem_read_d  = 1'b1;
                        mem_write_d = 1'b0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = DONE;
                    if (cur_grant_q == GRANT_I) begin
                        i_rdata_d = mem_rdata;
                        i_ack_d   = 1'b1;
                        i_done_s  = 1'b1;
                    end else begin
                        if (!mem_write_q) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            d_rdata_d = d_rdata_q;
                        end
                        d_ack_d  = 1'b1;
                        d_done_s = 1'b1;
                    end
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;
            cur_grant_q  <= GRANT_I;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= {WORD_SIZE{1'b0}};
            mem_wdata_q  <= {WORD_SIZE{1'b0}};
            i_rdata_q    <= {WORD_SIZE{1'b0}};
            d_rdata_q    <= {WORD_SIZE{1'b0}};
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cur_grant_q  <= cur_grant_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
        end
    end

    access_counter #(.WIDTH(WORD_SIZE)) u_icnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (i_done_s),
        .count_o (num_iacc)
    );

    access_counter #(.WIDTH(WORD_SIZE)) u_dcnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (d_done_s),
        .count_o (num_dacc)
    );

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, randomized traffic,
// and a narrow-width instance to exercise counter wrap.
module tb_mem_arbiter;

    localparam int W  = 16;
    localparam int SW = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         i_req, d_req, d_we, mem_ready;
    logic [W-1:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic         i_ack, d_ack, mem_read, mem_write;
    logic [W-1:0] i_rdata, d_rdata, mem_addr, mem_wdata, num_iacc, num_dacc;

    logic          s_reset_n;
    logic          s_i_ack, s_d_ack, s_mem_read, s_mem_write;
    logic [SW-1:0] s_i_rdata, s_d_rdata, s_mem_addr, s_mem_wdata, s_num_iacc, s_num_dacc;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.WORD_SIZE(W)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .num_iacc(num_iacc), .num_dacc(num_dacc)
    );

    // Narrow instance: a single store requester with a zero-wait memory.
    mem_arbiter #(.WORD_SIZE(SW)) u_small (
        .clk(clk), .reset_n(s_reset_n),
        .i_req(1'b0), .i_addr(4'h0), .i_ack(s_i_ack), .i_rdata(s_i_rdata),
        .d_req(1'b1), .d_we(1'b1), .d_addr(4'h3), .d_wdata(4'h9),
        .d_ack(s_d_ack), .d_rdata(s_d_rdata),
        .mem_read(s_mem_read), .mem_write(s_mem_write), .mem_addr(s_mem_addr),
        .mem_wdata(s_mem_wdata), .mem_rdata(4'h5), .mem_ready(1'b1),
        .num_iacc(s_num_iacc), .num_dacc(s_num_dacc)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (one access in flight) ----------------
    // m_busy: an access is outstanding at the memory; m_done: its ack cycle.
    logic         m_busy, m_done, m_side, m_we, m_last;   // side/last: 1 = D
    logic [W-1:0] m_addr, m_wdata, m_irdata, m_drdata, m_icnt, m_dcnt;

    function automatic logic choose(input logic ir, input logic dr, input logic last);
        if (ir && dr) return ~last;
        return dr;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_side <= 1'b0; m_we <= 1'b0;
            m_last <= 1'b0; m_addr <= '0; m_wdata <= '0; m_irdata <= '0;
            m_drdata <= '0; m_icnt <= '0; m_dcnt <= '0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_busy) begin
            if (mem_ready) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                if (!m_side) begin
                    m_irdata <= mem_rdata;
                    m_icnt   <= m_icnt + 16'd1;
                end else begin
                    if (!m_we) m_drdata <= mem_rdata;
                    m_dcnt <= m_dcnt + 16'd1;
                end
            end
        end else if (i_req || d_req) begin
            m_busy <= 1'b1;
            m_side <= choose(i_req, d_req, m_last);
            m_last <= choose(i_req, d_req, m_last);
            if (choose(i_req, d_req, m_last)) begin
                m_we <= d_we; m_addr <= d_addr; m_wdata <= d_wdata;
            end else begin
                m_we <= 1'b0; m_addr <= i_addr;
            end
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("mem_read",  mem_read,  m_busy && !(m_side && m_we));
            chk("mem_write", mem_write, m_busy && m_side && m_we);
            chk("mem_addr",  mem_addr,  m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("i_ack",     i_ack,     m_done && !m_side);
            chk("d_ack",     d_ack,     m_done && m_side);
            chk("i_rdata",   i_rdata,   m_irdata);
            chk("d_rdata",   d_rdata,   m_drdata);
            chk("num_iacc",  num_iacc,  m_icnt);
            chk("num_dacc",  num_dacc,  m_dcnt);
            chk("ack_excl",  i_ack & d_ack, 1'b0);
            chk("strobe_excl", mem_read & mem_write, 1'b0);
        end
    end

    initial begin
        int seq_n;
        int hi;
        bit got;
        int acks;
        logic seq_side [8];

        reset_n = 1'b0; s_reset_n = 1'b0;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        cmp_en = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_i_ack", i_ack, 1'b0);
        chk("rst_num_iacc", num_iacc, 16'h0000);
        chk("rst_mem_addr", mem_addr, 16'h0000);

        // Zero-wait fetch: strobe in n+1, ack in n+2
        reset_n = 1'b1;
        i_req = 1'b1; i_addr = 16'h0010; mem_ready = 1'b1; mem_rdata = 16'hA5A5;
        @(negedge clk);
        chk("f_mem_read", mem_read, 1'b1);
        chk("f_mem_addr", mem_addr, 16'h0010);
        @(negedge clk);
        chk("f_i_ack", i_ack, 1'b1);
        chk("f_i_rdata", i_rdata, 16'hA5A5);
        chk("f_num_iacc", num_iacc, 16'h0001);
        i_req = 1'b0;
        @(negedge clk);
        chk("f_ack_pulse", i_ack, 1'b0);

        // Conflict right after reset: D first, then strict alternation
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        i_req = 1'b1; i_addr = 16'h0010;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234;
        @(negedge clk);
        chk("c_mem_write", mem_write, 1'b1);
        chk("c_mem_read", mem_read, 1'b0);
        chk("c_mem_addr", mem_addr, 16'h0200);
        chk("c_mem_wdata", mem_wdata, 16'h1234);
        seq_n = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if ((i_ack || d_ack) && seq_n < 8) begin
                seq_side[seq_n] = d_ack;
                seq_n++;
            end
        end
        chk("c_ack_count", seq_n, 4);
        for (int k = 0; k < seq_n; k++) chk("c_alternate", seq_side[k], (k % 2 == 0));
        i_req = 1'b0; d_req = 1'b0;
        repeat (3) @(negedge clk);

        // Load with five wait cycles
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0300; mem_ready = 1'b0; mem_rdata = 16'hFFFF;
        hi = 0; got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (mem_read) begin
                hi++;
                if (hi == 6) begin mem_ready = 1'b1; mem_rdata = 16'h00FF; end
            end
            if (d_ack) begin
                got = 1'b1;
                chk("ld_d_rdata", d_rdata, 16'h00FF);
                chk("ld_i_rdata", i_rdata, 16'hA5A5);
                d_req = 1'b0; mem_ready = 1'b0;
            end
        end
        chk("ld_read_cycles", hi, 6);
        chk("ld_ack_seen", got, 1'b1);

        // Reset during the BUSY phase of a store
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0400; d_wdata = 16'hBEEF; mem_ready = 1'b0;
        @(negedge clk);
        chk("rs_write_on", mem_write, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("rs_write_off", mem_write, 1'b0);
        chk("rs_addr_clr", mem_addr, 16'h0000);
        @(negedge clk);
        chk("rs_no_ack", i_ack | d_ack, 1'b0);
        chk("rs_dacc", num_dacc, 16'h0000);
        chk("rs_iacc", num_iacc, 16'h0000);
        d_req = 1'b0; reset_n = 1'b1;
        i_req = 1'b1; i_addr = 16'h0020; mem_ready = 1'b1; mem_rdata = 16'h1111;
        @(negedge clk);
        chk("rs_next_read", mem_read, 1'b1);
        chk("rs_next_addr", mem_addr, 16'h0020);
        @(negedge clk);
        chk("rs_next_ack", i_ack, 1'b1);
        chk("rs_next_rdata", i_rdata, 16'h1111);
        chk("rs_next_iacc", num_iacc, 16'h0001);
        i_req = 1'b0;

        // Randomized traffic, including mem_ready noise outside BUSY
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            mem_ready = ($urandom_range(0, 3) != 0);
            mem_rdata = 16'($urandom);
            if (i_req) begin
                if (i_ack) begin
                    i_req = ($urandom_range(0, 1) == 1);
                    i_addr = 16'($urandom);
                end else if ($urandom_range(0, 31) == 0) begin
                    i_req = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                i_req = 1'b1;
                i_addr = 16'($urandom);
            end
            if (d_req) begin
                if (d_ack) begin
                    d_req = ($urandom_range(0, 1) == 1);
                    d_we = $urandom_range(0, 1) == 1;
                    d_addr = 16'($urandom);
                    d_wdata = 16'($urandom);
                end else if ($urandom_range(0, 31) == 0) begin
                    d_req = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                d_req = 1'b1;
                d_we = $urandom_range(0, 1) == 1;
                d_addr = 16'($urandom);
                d_wdata = 16'($urandom);
            end
        end
        i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b1;
        repeat (4) @(negedge clk);

        // Counter wrap on the narrow instance: 15 stores, then one more
        s_reset_n = 1'b1;
        acks = 0;
        for (int c = 0; c < 80 && acks < 16; c++) begin
            @(negedge clk);
            if (s_d_ack) begin
                acks++;
                if (acks == 15) chk("wrap_pre", s_num_dacc, 4'hF);
            end
        end
        chk("wrap_acks", acks, 16);
        chk("wrap_dacc", s_num_dacc, 4'h0);
        chk("wrap_iacc", s_num_iacc, 4'h0);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
